// File: rtl/kinase_valve_sequencer.sv
// Kinase pad-array valve sequencer: vents released lines with flush pulses, then runs the pumps for the dwell.
// Latency: all outputs registered; an accepted step drives ctrl_* from the accept edge onward.
// Backpressure: step_ready only while idle with abort low. Optional PUMP_REVERSE_EN adds step_pump_rev.
module kinase_valve_sequencer #(
    parameter int NUM_CTRL_A   = 13,
    parameter int NUM_CTRL_S   = 4,
    parameter int NUM_PUMP_A   = 3,
    parameter int NUM_PUMP_B   = 2,
    parameter int PUMP_DIV     = 8,
    parameter int FLUSH_CYCLES = 4,
    parameter int DWELL_W      = 16,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  step_valid,
    output logic                  step_ready,
    input  logic [NUM_CTRL_A-1:0] step_ctrl_a,
    input  logic [NUM_CTRL_S-1:0] step_ctrl_s,
    input  logic                  step_pump_a_en,
    input  logic                  step_pump_b_en,
    input  logic [DWELL_W-1:0]    step_dwell,
    input  logic                  step_last,
`ifdef PUMP_REVERSE_EN
    input  logic                  step_pump_rev,
`endif
    input  logic                  abort,
    output logic [NUM_CTRL_A-1:0] ctrl_a,
    output logic [NUM_CTRL_S-1:0] ctrl_s,
    output logic [NUM_PUMP_A-1:0] pump_a,
    output logic [NUM_PUMP_B-1:0] pump_b,
    output logic [NUM_CTRL_A-1:0] flush_ctrl_a,
    output logic [NUM_CTRL_S-1:0] flush_ctrl_s,
    output logic [NUM_PUMP_A-1:0] flush_pump_a,
    output logic [NUM_PUMP_B-1:0] flush_pump_b,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      step_count
);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} state_t;

    localparam int PA_W  = $clog2(NUM_PUMP_A);
    localparam int PB_W  = $clog2(NUM_PUMP_B);
    localparam int DIV_W = (PUMP_DIV > 1) ? $clog2(PUMP_DIV) : 1;
    localparam int FC_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    localparam logic [PA_W-1:0]    PA_LAST   = PA_W'(NUM_PUMP_A - 1);
    localparam logic [PB_W-1:0]    PB_LAST   = PB_W'(NUM_PUMP_B - 1);
    localparam logic [PA_W-1:0]    PA_ONE    = PA_W'(1);
    localparam logic [PB_W-1:0]    PB_ONE    = PB_W'(1);
    localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(PUMP_DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
    localparam logic [FC_W-1:0]    FC_LAST   = FC_W'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
    localparam logic [FC_W-1:0]    FC_ONE    = FC_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ONE = DWELL_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);

    state_t               state_q, state_d;
    logic                 pa_en_q, pa_en_d, pb_en_q, pb_en_d;
    logic                 rev_q, rev_d, last_q, last_d;
    logic                 abort_flush_q, abort_flush_d, clr_cnt_q, clr_cnt_d;
    logic [DWELL_W-1:0]   run_cnt_q, run_cnt_d;
    logic [FC_W-1:0]      fcnt_q, fcnt_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [PA_W-1:0]      pa_ph_q, pa_ph_d;
    logic [PB_W-1:0]      pb_ph_q, pb_ph_d;
    logic [NUM_CTRL_A-1:0] ctrl_a_d, flush_ctrl_a_d, rel_a;
    logic [NUM_CTRL_S-1:0] ctrl_s_d, flush_ctrl_s_d, rel_s;
    logic [NUM_PUMP_A-1:0] pump_a_d, flush_pump_a_d;
    logic [NUM_PUMP_B-1:0] pump_b_d, flush_pump_b_d;
    logic                 busy_d, done_d, step_ready_d, rev_in;
    logic [CNT_W-1:0]     step_count_d;

`ifdef PUMP_REVERSE_EN
    assign rev_in = step_pump_rev;
`else
    assign rev_in = 1'b0;
`endif

    // Pump drive: every valve closed except the one at the current phase.
    function automatic logic [NUM_PUMP_A-1:0] pat_a(input logic en, input logic [PA_W-1:0] ph);
        return en ? ~({{(NUM_PUMP_A-1){1'b0}}, 1'b1} << ph) : '0;
    endfunction

    function automatic logic [NUM_PUMP_B-1:0] pat_b(input logic en, input logic [PB_W-1:0] ph);
        return en ? ~({{(NUM_PUMP_B-1){1'b0}}, 1'b1} << ph) : '0;
    endfunction

    function automatic logic [PA_W-1:0] adv_a(input logic [PA_W-1:0] ph, input logic rev);
        if (rev) return (ph == '0) ? PA_LAST : ph - PA_ONE;
        return (ph == PA_LAST) ? '0 : ph + PA_ONE;
    endfunction

    function automatic logic [PB_W-1:0] adv_b(input logic [PB_W-1:0] ph, input logic rev);
        if (rev) return (ph == '0) ? PB_LAST : ph - PB_ONE;
        return (ph == PB_LAST) ? '0 : ph + PB_ONE;
    endfunction

    always_comb begin
        state_d        = state_q;
        pa_en_d        = pa_en_q;
        pb_en_d        = pb_en_q;
        rev_d          = rev_q;
        last_d         = last_q;
        abort_flush_d  = abort_flush_q;
        clr_cnt_d      = 1'b0;
        run_cnt_d      = run_cnt_q;
        fcnt_d         = fcnt_q;
        div_d          = div_q;
        pa_ph_d        = pa_ph_q;
        pb_ph_d        = pb_ph_q;
        ctrl_a_d       = ctrl_a;
        ctrl_s_d       = ctrl_s;
        pump_a_d       = '0;
        pump_b_d       = '0;
        flush_ctrl_a_d = '0;
        flush_ctrl_s_d = '0;
        flush_pump_a_d = '0;
        flush_pump_b_d = '0;
        done_d         = 1'b0;
        step_count_d   = step_count;
        rel_a          = '0;
        rel_s          = '0;

        if (abort) begin
            // Emergency release: vent everything that is currently pressurised.
            rel_a         = ctrl_a;
            rel_s         = ctrl_s;
            ctrl_a_d      = '0;
            ctrl_s_d      = '0;
            abort_flush_d = 1'b1;
            if ((FLUSH_CYCLES > 0) && ((|rel_a) || (|rel_s))) begin
                state_d        = FLUSH;
                fcnt_d         = FC_LAST;
                flush_ctrl_a_d = rel_a;
                flush_ctrl_s_d = rel_s;
                flush_pump_a_d = '1;
                flush_pump_b_d = '1;
            end else begin
                state_d = IDLE;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (step_valid && step_ready) begin
                        rel_a         = ctrl_a & ~step_ctrl_a;
                        rel_s         = ctrl_s & ~step_ctrl_s;
                        ctrl_a_d      = step_ctrl_a;
                        ctrl_s_d      = step_ctrl_s;
                        pa_en_d       = step_pump_a_en;
                        pb_en_d       = step_pump_b_en;
                        rev_d         = rev_in;
                        last_d        = step_last;
                        abort_flush_d = 1'b0;
                        run_cnt_d     = (step_dwell == '0) ? '0 : step_dwell - DWELL_ONE;
                        div_d         = '0;
                        pa_ph_d       = '0;
                        pb_ph_d       = '0;
                        if ((FLUSH_CYCLES > 0) && ((|rel_a) || (|rel_s))) begin
                            state_d        = FLUSH;
                            fcnt_d         = FC_LAST;
                            flush_ctrl_a_d = rel_a;
                            flush_ctrl_s_d = rel_s;
                            flush_pump_a_d = '1;
                            flush_pump_b_d = '1;
                        end else begin
                            state_d  = RUN;
                            pump_a_d = pat_a(step_pump_a_en, '0);
                            pump_b_d = pat_b(step_pump_b_en, '0);
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt_q == '0) begin
                        if (abort_flush_q) begin
                            state_d = IDLE;
                        end else begin
                            state_d  = RUN;
                            pump_a_d = pat_a(pa_en_q, pa_ph_q);
                            pump_b_d = pat_b(pb_en_q, pb_ph_q);
                        end
                    end else begin
                        fcnt_d         = fcnt_q - FC_ONE;
                        flush_ctrl_a_d = flush_ctrl_a;
                        flush_ctrl_s_d = flush_ctrl_s;
                        flush_pump_a_d = flush_pump_a;
                        flush_pump_b_d = flush_pump_b;
                    end
                end
                RUN: begin
                    if (run_cnt_q == '0) begin
                        state_d      = IDLE;
                        step_count_d = step_count + CNT_ONE;
                        if (last_q) begin
                            done_d    = 1'b1;
                            clr_cnt_d = 1'b1;
                        end
                    end else begin
                        run_cnt_d = run_cnt_q - DWELL_ONE;
                        if (div_q == DIV_LAST) begin
                            div_d   = '0;
                            pa_ph_d = adv_a(pa_ph_q, rev_q);
                            pb_ph_d = adv_b(pb_ph_q, rev_q);
                        end else begin
                            div_d = div_q + DIV_ONE;
                        end
                        pump_a_d = pat_a(pa_en_q, pa_ph_d);
                        pump_b_d = pat_b(pb_en_q, pb_ph_d);
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // The program-end clear lands one cycle after the done pulse.
        if (clr_cnt_q) step_count_d = '0;

        busy_d       = (state_d != IDLE);
        step_ready_d = (state_d == IDLE) && !abort;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pa_en_q       <= 1'b0;
            pb_en_q       <= 1'b0;
            rev_q         <= 1'b0;
            last_q        <= 1'b0;
            abort_flush_q <= 1'b0;
            clr_cnt_q     <= 1'b0;
            run_cnt_q     <= '0;
            fcnt_q        <= '0;
            div_q         <= '0;
            pa_ph_q       <= '0;
            pb_ph_q       <= '0;
            ctrl_a        <= '0;
            ctrl_s        <= '0;
            pump_a        <= '0;
            pump_b        <= '0;
            flush_ctrl_a  <= '0;
            flush_ctrl_s  <= '0;
            flush_pump_a  <= '0;
            flush_pump_b  <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            step_ready    <= 1'b0;
            step_count    <= '0;
        end else begin
            state_q       <= state_d;
            pa_en_q       <= pa_en_d;
            pb_en_q       <= pb_en_d;
            rev_q         <= rev_d;
            last_q        <= last_d;
            abort_flush_q <= abort_flush_d;
            clr_cnt_q     <= clr_cnt_d;
            run_cnt_q     <= run_cnt_d;
            fcnt_q        <= fcnt_d;
            div_q         <= div_d;
            pa_ph_q       <= pa_ph_d;
            pb_ph_q       <= pb_ph_d;
            ctrl_a        <= ctrl_a_d;
            ctrl_s        <= ctrl_s_d;
            pump_a        <= pump_a_d;
            pump_b        <= pump_b_d;
            flush_ctrl_a  <= flush_ctrl_a_d;
            flush_ctrl_s  <= flush_ctrl_s_d;
            flush_pump_a  <= flush_pump_a_d;
            flush_pump_b  <= flush_pump_b_d;
            busy          <= busy_d;
            done          <= done_d;
            step_ready    <= step_ready_d;
            step_count    <= step_count_d;
        end
    end

endmodule
